// File: rtl/rom_pkg.sv
// Shared definitions for the operand memory: geometry, loader states and
// the packed operand field positions used by both write and read sides.
package rom_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RAM_DEPTH  = 256;
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);

  // Packed operand word layout: {a, b}
  localparam int OPA_MSB = 31;
  localparam int OPA_LSB = 16;
  localparam int OPB_MSB = 15;
  localparam int OPB_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/word_dup_detect.sv
// Flags a written word equal to the previous word written in the same load.
// The first write after a clear never flags.
module word_dup_detect #(
  parameter int DATA_WIDTH = rom_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  dup_out
);

  logic [DATA_WIDTH-1:0] prev_word;
  logic                  have_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      dup_out   <= 1'b0;
    end else if (clear) begin
      have_prev <= 1'b0;
      dup_out   <= 1'b0;
    end else if (we) begin
      dup_out   <= have_prev && (wdata == prev_word);
      prev_word <= wdata;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_loader_sp.sv
// Stream-to-RAM loader: writes accepted words to consecutive addresses from a
// programmable base, wrapping modulo depth, with a one-cycle write latency.
module ram_loader_sp #(
  parameter  int DATA_WIDTH = rom_pkg::DATA_WIDTH,
  parameter  int RAM_DEPTH  = rom_pkg::RAM_DEPTH,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  dup_out
);

  import rom_pkg::*;

  localparam int                    LEN_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0]  DEPTH_LEN = LEN_WIDTH'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  length_sat;
  logic                  xfer;
  logic                  load_start;

  always_comb begin
    s_ready    = (state == LOAD);
    xfer       = s_valid && s_ready;
    load_start = (state == IDLE) && start;
    length_sat = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      remaining     <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            wr_ptr        <= base_addr;
            remaining     <= length_sat;
            words_written <= '0;
            busy          <= 1'b1;
            if (length_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            ram_we        <= 1'b1;
            ram_addr      <= wr_ptr;
            ram_wdata     <= s_data;
            // explicit wrap keeps non-power-of-two depths in range
            wr_ptr        <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            remaining     <= remaining - 1'b1;
            words_written <= words_written + 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_dup_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dup (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (load_start),
    .we      (xfer),
    .wdata   (s_data),
    .dup_out (dup_out)
  );

endmodule

// File: tb/tb_ram_loader_sp.sv
// Randomized self-checking bench for ram_loader_sp against a per-load model
// of expected write addresses, data, duplicate flags and completion timing.
module tb_ram_loader_sp;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
  logic          dup_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] words[$];

  ram_loader_sp #(
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .dup_out       (dup_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_words_written"}, words_written, 0);
    check({tag, "_dup_out"}, dup_out, 0);
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(3) == 0) words.push_back(words[i-1]);
      else words.push_back($urandom);
    end
  endtask

  // mode 0: back-to-back, 1: random stalls, 2: two idle cycles after each word.
  // Called #1 after a rising edge with the loader idle.
  task automatic run_load(input logic [AW-1:0] base, input int len, input int mode);
    int n;
    int idx;
    int gap;
    int cyc;
    logic pend;
    logic [AW-1:0] exp_addr;
    n   = (len > DEPTH) ? DEPTH : len;
    idx = 0;
    gap = 0;
    cyc = 0;
    start     = 1'b1;
    base_addr = base;
    length    = len[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_words_cleared", words_written, 0);
    check("start_dup_cleared", dup_out, 0);
    check("start_no_we", ram_we, 0);
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_s_ready", s_ready, 0);
    end else begin
      check("load_s_ready", s_ready, 1);
      check("load_done_low", done, 0);
      while (idx < n && cyc < 8 * n + 32) begin
        pend = (mode == 0) || (mode == 1 && $urandom_range(99) >= 30) || (mode == 2 && gap == 0);
        s_valid   = pend;
        s_data    = pend ? words[idx] : $urandom;
        start     = ($urandom_range(3) == 0);
        base_addr = $urandom;
        length    = 9'($urandom_range(1, 300));
        @(posedge clk); #1;
        cyc++;
        if (pend) begin
          exp_addr = base + AW'(idx);
          check("wr_we", ram_we, 1);
          check("wr_addr", ram_addr, exp_addr);
          check("wr_data", ram_wdata, words[idx]);
          check("wr_dup", dup_out, (idx > 0) && (words[idx] == words[idx-1]));
          check("wr_count", words_written, idx + 1);
          check("wr_done", done, (idx + 1 == n));
          idx++;
          gap = (mode == 2) ? 2 : 0;
        end else begin
          check("wait_no_we", ram_we, 0);
          check("wait_done_low", done, 0);
          check("wait_s_ready", s_ready, 1);
          if (gap > 0) gap--;
        end
      end
      if (idx < n) check("load_timeout", idx, n);
      s_valid = 1'b0;
      start   = 1'b0;
    end
    @(posedge clk); #1;
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_s_ready", s_ready, 0);
    check("end_no_we", ram_we, 0);
    check("end_count_held", words_written, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    #23;
    check_all_zero("reset");
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    words = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
    run_load(8'h10, 4, 0);

    fill_random(4);
    run_load(8'hFE, 4, 0);

    fill_random(3);
    run_load(8'h33, 3, 2);

    words = '{32'hAAAA5555, 32'hAAAA5555, 32'h12345678};
    run_load(8'h20, 3, 0);
    words = '{32'h12345678, 32'h12345678};
    run_load(8'h30, 2, 0);

    run_load(8'h05, 0, 0);

    fill_random(300);
    run_load(8'h80, 300, 1);

    // Reset in the middle of a five-word load
    fill_random(5);
    start     = 1'b1;
    base_addr = 8'h40;
    length    = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      @(posedge clk); #1;
      check("pre_reset_we", ram_we, 1);
      check("pre_reset_addr", ram_addr, 8'h40 + 8'(i));
    end
    s_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_abort");
    fill_random(5);
    run_load(8'h70, 5, 0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 40);
      fill_random(len);
      run_load(AW'($urandom), len, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
